// File: rtl/brisc_mem_pkg.sv
// rtl/brisc_mem_pkg.sv - shared encodings for the core-side cache request master
package brisc_mem_pkg;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_RESP = 2'd2;
    localparam logic [1:0] ST_RESP      = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        ISSUE     = ST_ISSUE,
        WAIT_RESP = ST_WAIT_RESP,
        RESP      = ST_RESP
    } req_state_t;

    localparam logic REQ_LOAD  = 1'b0;
    localparam logic REQ_STORE = 1'b1;

    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/cache_request_master.sv
// rtl/cache_request_master.sv - single-outstanding load/store initiator toward a cache responder
// Optional watchdog completion with core_resp_error is built when REQ_TIMEOUT_EN is defined.
module cache_request_master
    import brisc_mem_pkg::*;
#(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_BITS   = 12,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    core_req_valid,
    input  logic                    core_req_write,
    input  logic [ADDRESS_BITS-1:0] core_req_addr,
    input  logic [DATA_WIDTH-1:0]   core_req_data,
    output logic                    core_req_ready,
    output logic                    core_resp_valid,
    output logic [ADDRESS_BITS-1:0] core_resp_addr,
    output logic [DATA_WIDTH-1:0]   core_resp_data,
    output logic                    core_resp_error,
    output logic                    stall,
    output logic                    cache_read,
    output logic                    cache_write,
    output logic [ADDRESS_BITS-1:0] cache_address,
    output logic [DATA_WIDTH-1:0]   cache_in_data,
    input  logic                    cache_ready,
    input  logic                    cache_valid,
    input  logic [ADDRESS_BITS-1:0] cache_out_addr,
    input  logic [DATA_WIDTH-1:0]   cache_out_data
);

    req_state_t state;
    logic       write_q;
    logic       addr_match;
    logic       complete;
    logic       capture;

    // cache_address / cache_in_data double as the held request address and store data
    assign addr_match     = cache_valid && (cache_out_addr == cache_address);
    assign core_req_ready = (state == IDLE) && reset;
    assign stall          = (state == ISSUE) || (state == WAIT_RESP);

    always_comb begin
        complete = 1'b0;
        capture  = 1'b0;
        case (state)
            ISSUE: begin
                if (cache_ready) begin
                    if (write_q == REQ_STORE) begin
                        complete = 1'b1;
                    end else if (addr_match) begin
                        complete = 1'b1;
                        capture  = 1'b1;
                    end
                end
            end
            WAIT_RESP: begin
                if (addr_match) begin
                    complete = 1'b1;
                    capture  = 1'b1;
                end
            end
            default: ;
        endcase
    end

`ifdef REQ_TIMEOUT_EN
    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  timed_out;

    assign timed_out = (wait_cnt >= TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            wait_cnt        <= '0;
            core_resp_error <= 1'b0;
        end else begin
            core_resp_error <= 1'b0;
            if (state == IDLE) begin
                wait_cnt <= '0;
            end else if (stall && (wait_cnt != '1)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (stall && !complete && timed_out) begin
                core_resp_error <= 1'b1;
            end
        end
    end
`else
    logic timed_out;
    assign timed_out       = 1'b0;
    assign core_resp_error = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            state           <= IDLE;
            write_q         <= REQ_LOAD;
            core_resp_valid <= 1'b0;
            core_resp_addr  <= '0;
            core_resp_data  <= '0;
            cache_read      <= 1'b0;
            cache_write     <= 1'b0;
            cache_address   <= '0;
            cache_in_data   <= '0;
        end else begin
            core_resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (core_req_valid) begin
                        write_q       <= core_req_write;
                        cache_address <= core_req_addr;
                        cache_in_data <= core_req_data;
                        cache_read    <= (core_req_write == REQ_LOAD);
                        cache_write   <= (core_req_write == REQ_STORE);
                        state         <= ISSUE;
                    end
                end
                ISSUE, WAIT_RESP: begin
                    if (complete || timed_out) begin
                        state           <= RESP;
                        cache_read      <= 1'b0;
                        cache_write     <= 1'b0;
                        core_resp_valid <= 1'b1;
                        core_resp_addr  <= cache_address;
                        core_resp_data  <= capture ? cache_out_data : '0;
                    end else if (state == ISSUE && cache_ready) begin
                        state <= WAIT_RESP;
                    end else if (state == WAIT_RESP && !cache_ready) begin
                        state <= ISSUE;
                    end
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_request_master.sv
// tb/tb_cache_request_master.sv - directed self-checking bench for cache_request_master
module tb_cache_request_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        core_req_valid;
    logic        core_req_write;
    logic [11:0] core_req_addr;
    logic [31:0] core_req_data;
    logic        core_req_ready;
    logic        core_resp_valid;
    logic [11:0] core_resp_addr;
    logic [31:0] core_resp_data;
    logic        core_resp_error;
    logic        stall;
    logic        cache_read;
    logic        cache_write;
    logic [11:0] cache_address;
    logic [31:0] cache_in_data;
    logic        cache_ready;
    logic        cache_valid;
    logic [11:0] cache_out_addr;
    logic [31:0] cache_out_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cache_request_master #(
        .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(12), .TIMEOUT_CYCLES(8)
    ) dut (
        .clock(clock), .reset(reset),
        .core_req_valid(core_req_valid), .core_req_write(core_req_write),
        .core_req_addr(core_req_addr), .core_req_data(core_req_data),
        .core_req_ready(core_req_ready),
        .core_resp_valid(core_resp_valid), .core_resp_addr(core_resp_addr),
        .core_resp_data(core_resp_data), .core_resp_error(core_resp_error),
        .stall(stall),
        .cache_read(cache_read), .cache_write(cache_write),
        .cache_address(cache_address), .cache_in_data(cache_in_data),
        .cache_ready(cache_ready), .cache_valid(cache_valid),
        .cache_out_addr(cache_out_addr), .cache_out_data(cache_out_data)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [11:0] addr, input logic [31:0] data);
        core_req_valid = 1'b1;
        core_req_write = wr;
        core_req_addr  = addr;
        core_req_data  = data;
        @(negedge clock);
        core_req_valid = 1'b0;
    endtask

    initial begin
        int resp_cycle;
        logic resp_err;
        logic [31:0] resp_dat;

        reset = 1'b0;
        core_req_valid = 1'b0; core_req_write = 1'b0;
        core_req_addr = '0; core_req_data = '0;
        cache_ready = 1'b0; cache_valid = 1'b0;
        cache_out_addr = '0; cache_out_data = '0;
        repeat (2) @(negedge clock);
        chk("rst_ready", {31'd0, core_req_ready}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_resp_valid", {31'd0, core_resp_valid}, 32'd0);
        chk("rst_strobes", {30'd0, cache_read, cache_write}, 32'd0);
        chk("rst_addr", {20'd0, cache_address}, 32'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("post_rst_ready", {31'd0, core_req_ready}, 32'd1);

        // best-case load: hit in the first ISSUE cycle
        cache_ready = 1'b1; cache_valid = 1'b1;
        cache_out_addr = 12'h010; cache_out_data = 32'hDEADBEEF;
        request(1'b0, 12'h010, 32'h0);
        chk("ld_stall", {31'd0, stall}, 32'd1);
        chk("ld_read", {30'd0, cache_read, cache_write}, 32'd2);
        chk("ld_addr", {20'd0, cache_address}, 32'h010);
        chk("ld_ready_busy", {31'd0, core_req_ready}, 32'd0);
        chk("ld_no_early_resp", {31'd0, core_resp_valid}, 32'd0);
        @(negedge clock);
        chk("ld_resp_valid", {31'd0, core_resp_valid}, 32'd1);
        chk("ld_resp_data", core_resp_data, 32'hDEADBEEF);
        chk("ld_resp_addr", {20'd0, core_resp_addr}, 32'h010);
        chk("ld_stall_done", {31'd0, stall}, 32'd0);
        chk("ld_strobes_off", {30'd0, cache_read, cache_write}, 32'd0);
        @(negedge clock);
        chk("ld_pulse_end", {31'd0, core_resp_valid}, 32'd0);
        chk("ld_ready_again", {31'd0, core_req_ready}, 32'd1);

        // store completes on the first ready ISSUE cycle
        cache_valid = 1'b0;
        request(1'b1, 12'h020, 32'h12345678);
        chk("st_strobes", {30'd0, cache_read, cache_write}, 32'd1);
        chk("st_addr", {20'd0, cache_address}, 32'h020);
        chk("st_data", cache_in_data, 32'h12345678);
        @(negedge clock);
        chk("st_resp_valid", {31'd0, core_resp_valid}, 32'd1);
        chk("st_resp_data", core_resp_data, 32'h0);
        chk("st_resp_addr", {20'd0, core_resp_addr}, 32'h020);
        chk("st_write_off", {31'd0, cache_write}, 32'd0);
        @(negedge clock);

        // load held through 5 not-ready cycles
        cache_ready = 1'b0;
        request(1'b0, 12'h030, 32'h0);
        for (int i = 0; i < 5; i++) begin
            chk("nr_hold", {18'd0, stall, core_resp_valid, cache_read, cache_write, cache_address},
                {18'd0, 1'b1, 1'b0, 1'b1, 1'b0, 12'h030});
            if (i < 4) @(negedge clock);
        end
        cache_ready = 1'b1; cache_valid = 1'b1;
        cache_out_addr = 12'h030; cache_out_data = 32'hCAFEF00D;
        @(negedge clock);
        chk("nr_resp_valid", {31'd0, core_resp_valid}, 32'd1);
        chk("nr_resp_data", core_resp_data, 32'hCAFEF00D);
        cache_valid = 1'b0; cache_ready = 1'b0;
        @(negedge clock);
        chk("nr_single_pulse", {31'd0, core_resp_valid}, 32'd0);

        // mismatched echo in WAIT_RESP is ignored
        cache_ready = 1'b1;
        request(1'b0, 12'h010, 32'h0);
        @(negedge clock);
        cache_valid = 1'b1; cache_out_addr = 12'h011; cache_out_data = 32'h11111111;
        @(negedge clock);
        chk("mm_ignored_valid", {31'd0, core_resp_valid}, 32'd0);
        chk("mm_still_stall", {31'd0, stall}, 32'd1);
        cache_out_addr = 12'h010; cache_out_data = 32'hA5A5A5A5;
        @(negedge clock);
        chk("mm_resp_valid", {31'd0, core_resp_valid}, 32'd1);
        chk("mm_resp_data", core_resp_data, 32'hA5A5A5A5);
        cache_valid = 1'b0;
        @(negedge clock);

        // reset during WAIT_RESP aborts the request
        request(1'b0, 12'h040, 32'h0);
        @(negedge clock);
        chk("ra_in_wait", {31'd0, stall}, 32'd1);
        reset = 1'b0;
        cache_valid = 1'b1; cache_out_addr = 12'h040; cache_out_data = 32'h77777777;
        @(negedge clock);
        chk("ra_outputs", {26'd0, core_req_ready, stall, core_resp_valid, core_resp_error, cache_read, cache_write},
            32'd0);
        chk("ra_addr", {20'd0, cache_address}, 32'd0);
        reset = 1'b1; cache_valid = 1'b0;
        @(negedge clock);
        chk("ra_ready", {31'd0, core_req_ready}, 32'd1);
        chk("ra_no_resp", {31'd0, core_resp_valid}, 32'd0);

        // responder never ready: watchdog or indefinite stall
        cache_ready = 1'b0;
        resp_cycle = 0; resp_err = 1'b0; resp_dat = 32'hFFFFFFFF;
        request(1'b0, 12'h050, 32'h0);
        for (int i = 1; i <= 100; i++) begin
            if (core_resp_valid && resp_cycle == 0) begin
                resp_cycle = i; resp_err = core_resp_error; resp_dat = core_resp_data;
            end
            if (i < 100) @(negedge clock);
        end
`ifdef REQ_TIMEOUT_EN
        chk("to_cycle", resp_cycle, 32'd8);
        chk("to_error", {31'd0, resp_err}, 32'd1);
        chk("to_data", resp_dat, 32'd0);
`else
        chk("to_no_resp", resp_cycle, 32'd0);
        chk("to_stall", {31'd0, stall}, 32'd1);
        chk("to_error_tied", {31'd0, core_resp_error}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
